// File: rtl/pmem_line_adaptor_if.sv
// Bundle of the cache-line side and memory-burst side signals of the line adaptor.
// slave is the adaptor's view; master is the view of the cache plus memory around it.
interface pmem_line_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [31:0]            line_address;
  logic                   line_read;
  logic                   line_write;
  logic [LINE_WIDTH-1:0]  line_wdata;
  logic [LINE_WIDTH-1:0]  line_rdata;
  logic                   line_resp;
  logic [31:0]            burst_address;
  logic                   burst_read;
  logic                   burst_write;
  logic [BURST_WIDTH-1:0] burst_wdata;
  logic [BURST_WIDTH-1:0] burst_rdata;
  logic                   burst_resp;

  modport slave (
    input  line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/pmem_line_adaptor.sv
// Services one 256-bit cache line read or write at a time as a 4-beat 64-bit memory burst.
// Read beats land directly in the line_rdata register; write lines are sliced from a private copy.
module pmem_line_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input logic               clk,
  input logic               rst,
  pmem_line_adaptor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             beat_cnt;
  logic [LINE_WIDTH-1:0]  rd_line;
  logic [LINE_WIDTH-1:0]  wr_line;
  logic [31:0]            addr_q;
  logic                   last_beat;

  assign last_beat         = bus.burst_resp && (beat_cnt == 2'd3);
  assign bus.line_rdata    = rd_line;
  assign bus.burst_address = addr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.line_read)       state_next = READ;
        else if (bus.line_write) state_next = WRITE;
      end
      READ:    if (last_beat) state_next = RESP;
      WRITE:   if (last_beat) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The 2-bit counter naturally wraps to 0 on the final beat, which is also the state exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 2'd0;
      rd_line  <= '0;
      wr_line  <= '0;
      addr_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.line_read) begin
            addr_q   <= {bus.line_address[31:5], 5'b0};
            beat_cnt <= 2'd0;
          end else if (bus.line_write) begin
            addr_q   <= {bus.line_address[31:5], 5'b0};
            wr_line  <= bus.line_wdata;
            beat_cnt <= 2'd0;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            rd_line[int'(beat_cnt)*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_rdata;
            beat_cnt <= beat_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (bus.burst_resp) beat_cnt <= beat_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.burst_read  = (state == READ);
    bus.burst_write = (state == WRITE);
    bus.line_resp   = (state == RESP);
    bus.burst_wdata = wr_line[int'(beat_cnt)*BURST_WIDTH +: BURST_WIDTH];
  end

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Directed bench for pmem_line_adaptor: cache and memory are modelled by one initial block,
// with expected lines and write beats queued at request time and retired as the DUT responds.
module tb_pmem_line_adaptor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [255:0] lineQ[$];
  logic [63:0]  beatQ[$];
  logic [255:0] prevLine;

  pmem_line_adaptor_if bus ();

  pmem_line_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one line transaction starting in an IDLE cycle (cycle 0); respMask bit k raises
  // burst_resp in cycle k, and line_resp is required exactly in cycle expLat.
  task automatic applyStimulus(input bit isWrite, input bit alsoWrite, input logic [31:0] addr,
                               input logic [255:0] data, input logic [15:0] respMask,
                               input int expLat, input bit scramble, input string tag);
    logic [31:0] expAddr;
    int          beatIdx;
    expAddr          = {addr[31:5], 5'b0};
    beatIdx          = 0;
    bus.burst_resp   = 1'b0;
    bus.line_address = addr;
    bus.line_read    = !isWrite;
    bus.line_write   = isWrite || alsoWrite;
    bus.line_wdata   = data;
    if (isWrite) for (int k = 0; k < 4; k++) beatQ.push_back(data[64*k +: 64]);
    else lineQ.push_back(data);
    for (int cyc = 1; cyc <= expLat; cyc++) begin
      @(posedge clk); #1;
      bus.burst_resp = 1'b0;
      if (scramble && cyc == 1) begin
        bus.line_address = ~addr;
        bus.line_wdata   = ~data;
      end
      if (cyc < expLat) begin
        checkOutput({tag, ".resp_early"}, bus.line_resp, 1'b0);
        checkOutput({tag, ".dir"}, {bus.burst_read, bus.burst_write}, isWrite ? 2'b01 : 2'b10);
        checkOutput({tag, ".addr"}, bus.burst_address, expAddr);
        if (isWrite && beatQ.size() > 0) checkOutput({tag, ".wdata"}, bus.burst_wdata, beatQ[0]);
        if (respMask[cyc]) begin
          bus.burst_resp = 1'b1;
          if (isWrite) begin
            if (beatQ.size() > 0) void'(beatQ.pop_front());
          end else begin
            bus.burst_rdata = data[64*beatIdx +: 64];
          end
          beatIdx++;
        end
      end else begin
        checkOutput({tag, ".resp"}, bus.line_resp, 1'b1);
        if (!isWrite && lineQ.size() > 0) prevLine = lineQ.pop_front();
        checkOutput({tag, ".rdata"}, bus.line_rdata, prevLine);
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput({tag, ".resp_once"}, bus.line_resp, 1'b0);
    checkOutput({tag, ".idle"}, {bus.burst_read, bus.burst_write}, 2'b00);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    prevLine         = '0;
    rst              = 1'b1;
    bus.line_address = 32'd0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_wdata   = '0;
    bus.burst_rdata  = 64'd0;
    bus.burst_resp   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst.line_resp", bus.line_resp, 1'b0);
    checkOutput("rst.dir", {bus.burst_read, bus.burst_write}, 2'b00);
    checkOutput("rst.burst_address", bus.burst_address, 32'd0);
    checkOutput("rst.burst_wdata", bus.burst_wdata, 64'd0);
    checkOutput("rst.line_rdata", bus.line_rdata, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] aligned read, no stalls");
    applyStimulus(1'b0, 1'b0, 32'h0000_1234,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  16'h001E, 5, 1'b0, "read0");

    $display("[TB] write with stalls and mid-burst input changes");
    applyStimulus(1'b1, 1'b0, 32'h0000_ABCD,
                  {64'hD, 64'hC, 64'hB, 64'hA},
                  16'h0154, 9, 1'b1, "write0");

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b0, 1'b1, 32'h8000_0047,
                  {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                   64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                  16'h001E, 5, 1'b0, "simul.read");
    applyStimulus(1'b1, 1'b0, 32'h8000_0047,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                  16'h001E, 5, 1'b0, "simul.write");

    $display("[TB] read with stalls and address change");
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF,
                  {64'hA5A5_0000_1111_0004, 64'hA5A5_0000_1111_0003,
                   64'hA5A5_0000_1111_0002, 64'hA5A5_0000_1111_0001},
                  16'h005A, 7, 1'b1, "read1");

    $display("[TB] reset after second read beat");
    bus.line_address = 32'h0000_0040;
    bus.line_read    = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      bus.burst_resp  = (cyc <= 2);
      bus.burst_rdata = 64'h7777_0000_0000_0000 + 64'(cyc);
      if (cyc == 3) begin
        rst           = 1'b1;
        bus.line_read = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput("abort.line_resp", bus.line_resp, 1'b0);
    checkOutput("abort.dir", {bus.burst_read, bus.burst_write}, 2'b00);
    checkOutput("abort.burst_address", bus.burst_address, 32'd0);
    checkOutput("abort.burst_wdata", bus.burst_wdata, 64'd0);
    checkOutput("abort.line_rdata", bus.line_rdata, 256'd0);
    prevLine = '0;
    rst = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      checkOutput("abort.quiet", {bus.line_resp, bus.burst_read, bus.burst_write}, 3'b000);
    end
    applyStimulus(1'b0, 1'b0, 32'h0000_0040,
                  {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                   64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001},
                  16'h001E, 5, 1'b0, "abort.read");

    $display("[TB] stray handshake in IDLE");
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      checkOutput("stray.quiet", {bus.line_resp, bus.burst_read, bus.burst_write}, 3'b000);
      checkOutput("stray.line_rdata", bus.line_rdata, prevLine);
    end
    bus.burst_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h1234_5660,
                  {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                   64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001},
                  16'h001E, 5, 1'b0, "stray.read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_line_adaptor.md
# pmem_line_adaptor

Physical-memory-side responder for the L1 caches' 256-bit line interface. Accepts one line read or line write at a time from a cache (`pmem_address`, `pmem_rdata`, `pmem_wdata` side) and services it as a 4-beat, 64-bit burst to the off-chip memory port. Read beats are assembled into a full line before `line_resp` is asserted. Write lines are sliced into beats. Sits between the cache miss path (or the I/D arbiter) and main memory.

## Interface
- `LINE_WIDTH`, default 256: cache line width in bits; fixed at 256 for this design.
- `BURST_WIDTH`, default 64: memory beat width in bits; beats per line = LINE_WIDTH/BURST_WIDTH = 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `line_address`  in  32  cache-side line address; bits [4:0] are ignored.
- `line_read`  in  1  line read request; held high by the cache until `line_resp`.
- `line_write`  in  1  line write request; held high by the cache until `line_resp`.
- `line_wdata`  in  256  write line; beat k = bits [64k+63:64k].
- `line_rdata`  out  256  assembled read line; registered.
- `line_resp`  out  1  one-cycle completion pulse.
- `burst_address`  out  32  `{line_address[31:5], 5'b0}` latched at accept.
- `burst_read`  out  1  burst read request; held for the whole burst.
- `burst_write`  out  1  burst write request; held for the whole burst.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  read beat, valid when `burst_resp` is high.
- `burst_resp`  in  1  per-beat handshake: read beat valid, or write beat consumed.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. A 2-bit beat counter and a 256-bit line buffer.
- **IDLE:** requests are sampled only in IDLE.
  - If `line_read` is high: latch the aligned address, clear the counter, go to READ.
  - Else if `line_write` is high: latch the aligned address and `line_wdata`, clear the counter, go to WRITE.
  - Read has priority when both are high. The write is not lost; it is sampled again in the next IDLE.
- **READ:**
  - `burst_read`=1.
  - On `burst_resp`, write `burst_rdata` into buffer slot [counter] and increment the counter.
  - On `burst_resp` with counter==3, go to RESP.
  - Cycles without `burst_resp` hold all state (memory stalls are arbitrary).
- **WRITE:**
  - `burst_write`=1 and `burst_wdata` = buffer slot [counter].
  - On `burst_resp`, increment the counter.
  - On `burst_resp` with counter==3, go to RESP.
- **RESP:** `line_resp`=1 for exactly one cycle, then IDLE.
  - For reads, `line_rdata` equals the buffer.
  - `line_rdata` holds its value until the next read's first beat overwrites it. Writes do not disturb it.
- `line_address` and `line_wdata` changing after accept have no effect. The latched copies are used.
- `burst_resp` in IDLE or RESP is ignored.
- The counter wraps 3→0 only on state exit; no beat is ever written past slot 3.
- `burst_read` and `burst_write` are never high together.
- Upstream rule: the cache drops its request in the cycle after `line_resp`. A request still high in that following IDLE is treated as a new request.

## Timing
- **Reset values** (the cycle after `rst` is sampled high):
  - state=IDLE, counter=0, `line_resp`=0, `burst_read`=0, `burst_write`=0.
  - `burst_address`=0, `burst_wdata`=0, `line_rdata`=0, buffer=0.
- **Reset mid-burst:** the burst is abandoned and `burst_read`/`burst_write` drop next cycle. No `line_resp` is issued. The memory side must tolerate the abort.
- All outputs are driven from registers or decoded from state only. There is no combinational path from `burst_resp` to `line_resp`.
- **Read latency:**
  - Request seen high in IDLE at cycle 0.
  - `burst_read` is high in cycles 1 through the final beat.
  - With beats arriving in cycles 1–4, `line_resp`=1 in cycle 5.
  - Minimum latency is 5 cycles, plus one cycle per stall.
- **Write latency:** identical, 5 cycles minimum.
- **Back-to-back requests:** minimum spacing is 6 cycles (RESP → IDLE → accept).

## Test plan
- **Aligned read, no stalls:**
  - Stimulus: `line_read` with address 0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in consecutive cycles.
  - Required: `burst_address`=0x0000_1220; `line_resp` in cycle 5; `line_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write with stalls:**
  - Stimulus: `line_write` with `line_wdata`={64'hD,64'hC,64'hB,64'hA}. `burst_resp` high only on alternating cycles.
  - Required: `burst_wdata` presents A, B, C, D in order, each held until its `burst_resp`; `line_resp` in cycle 9; `line_rdata` unchanged.
- **Simultaneous requests:**
  - Stimulus: `line_read` and `line_write` both high in IDLE.
  - Required: read serviced first (`burst_read` high, `burst_write` low); the write is accepted in the IDLE after RESP.
- **Mid-burst input changes:**
  - Stimulus: `line_address` and `line_wdata` change after accept.
  - Required: `burst_address` and the beats are unchanged.
- **Reset after beat 2 of a read:**
  - Required: all outputs at reset values next cycle; no `line_resp`; a subsequent read completes normally.
- **Stray handshake:**
  - Stimulus: `burst_resp` pulsed in IDLE.
  - Required: no state change and no `line_resp`.
